// File: rtl/flash_cmd_seq_if.sv
// Bundles the host command port and the rom-controller byte-op port of
// flash_cmd_seq. The slave modport is the sequencer's view; the master modport
// is the environment (register file plus rom controller) driving it.
interface flash_cmd_seq_if #(
  parameter int ADDR_W = 19
);
  // Command side (from the ZX-bus register file)
  logic              cmd_valid;
  logic [2:0]        cmd_code;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_data;
  logic              cmd_ready;
  logic              done;
  logic [1:0]        err;
  logic [7:0]        rdata;

  // Byte-op side (to the rom controller)
  logic              op_req;
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [7:0]        op_wdata;
  logic              op_ack;
  logic [7:0]        op_rdata;

  modport slave (
    input  cmd_valid, cmd_code, cmd_addr, cmd_data,
    output cmd_ready, done, err, rdata,
    output op_req, op_we, op_addr, op_wdata,
    input  op_ack, op_rdata
  );

  modport master (
    output cmd_valid, cmd_code, cmd_addr, cmd_data,
    input  cmd_ready, done, err, rdata,
    input  op_req, op_we, op_addr, op_wdata,
    output op_ack, op_rdata
  );
endinterface

// File: rtl/flash_cmd_seq.sv
// JEDEC command sequencer for a 29F040-class parallel boot flash.
// Expands one host command into unlock/command byte writes, then polls DQ7/DQ5
// until the embedded algorithm finishes, fails or times out. One byte op is
// outstanding at a time on the rom controller's op port.
// Optional build macro FLASH_VERIFY_EN: after a successful PROGRAM poll, read
// the byte back once and flag err=3 on mismatch.
module flash_cmd_seq #(
  parameter int ADDR_W = 19,
  parameter int TMO_W  = 24
) (
  input  logic           clk,
  input  logic           rst,
  flash_cmd_seq_if.slave bus
);

  localparam logic [2:0] CMD_READ    = 3'd0;
  localparam logic [2:0] CMD_PROGRAM = 3'd1;
  localparam logic [2:0] CMD_SECTOR  = 3'd2;
  localparam logic [2:0] CMD_CHIP    = 3'd3;
  localparam logic [2:0] CMD_RESET   = 3'd4;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_DQ5     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_VERIFY  = 2'd3;

  localparam logic [ADDR_W-1:0] UNLOCK1 = ADDR_W'(12'h555);
  localparam logic [ADDR_W-1:0] UNLOCK2 = ADDR_W'(12'h2AA);
  localparam logic [TMO_W-1:0]  TMO_MAX = {TMO_W{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_POLL,
    S_CHK,
    S_DQ5RD,
    S_RSTWR,
`ifdef FLASH_VERIFY_EN
    S_VERIFY,
`endif
    S_FIN
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } op_t;

  // Number of byte ops a command expands into; 0 marks an illegal code.
  function automatic logic [2:0] seq_len(input logic [2:0] code);
    case (code)
      CMD_READ, CMD_RESET:  return 3'd1;
      CMD_PROGRAM:          return 3'd4;
      CMD_SECTOR, CMD_CHIP: return 3'd6;
      default:              return 3'd0;
    endcase
  endfunction

  // Address/data of byte op 'step' within the command's write sequence.
  function automatic op_t seq_op(input logic [2:0]        code,
                                 input logic [2:0]        step,
                                 input logic [ADDR_W-1:0] addr,
                                 input logic [7:0]        data);
    op_t op;
    op.we   = 1'b1;
    op.addr = UNLOCK1;
    op.data = 8'hAA;
    case (code)
      CMD_READ: begin
        op.we   = 1'b0;
        op.addr = addr;
        op.data = 8'h00;
      end
      CMD_RESET: begin
        op.addr = addr;
        op.data = 8'hF0;
      end
      CMD_PROGRAM: begin
        case (step)
          3'd0: ;
          3'd1: begin op.addr = UNLOCK2; op.data = 8'h55; end
          3'd2: begin op.addr = UNLOCK1; op.data = 8'hA0; end
          default: begin op.addr = addr; op.data = data; end
        endcase
      end
      CMD_SECTOR, CMD_CHIP: begin
        case (step)
          3'd0, 3'd3: ;
          3'd1, 3'd4: begin op.addr = UNLOCK2; op.data = 8'h55; end
          3'd2:       begin op.addr = UNLOCK1; op.data = 8'h80; end
          default: begin
            if (code == CMD_SECTOR) begin
              op.addr = addr;
              op.data = 8'h30;
            end else begin
              op.addr = UNLOCK1;
              op.data = 8'h10;
            end
          end
        endcase
      end
      default: ;
    endcase
    return op;
  endfunction

  state_e            state_q, state_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [2:0]        step_q, step_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [1:0]        err_q, err_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              op_req_q, op_req_d;
  logic              op_we_q, op_we_d;
  logic [ADDR_W-1:0] op_addr_q, op_addr_d;
  logic [7:0]        op_wdata_q, op_wdata_d;

  op_t               cur_op;
  logic [2:0]        n_steps;
  logic              polled;
  logic              expect_dq7;
  logic [TMO_W-1:0]  tmo_inc;
  state_e            pass_state;

  // State and datapath registers.
  // NOTE: every register here is a handful of flops (no memory arrays), so all
  // of them get a defined reset value; a mid-op reset drops op_req at once.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before this edge regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= 3'd0;
      addr_q      <= '0;
      data_q      <= 8'h00;
      step_q      <= 3'd0;
      tmo_q       <= '0;
      err_q       <= ERR_OK;
      rdata_q     <= 8'h00;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      op_req_q    <= 1'b0;
      op_we_q     <= 1'b0;
      op_addr_q   <= '0;
      op_wdata_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      step_q      <= step_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
      op_req_q    <= op_req_d;
      op_we_q     <= op_we_d;
      op_addr_q   <= op_addr_d;
      op_wdata_q  <= op_wdata_d;
    end
  end

  // Next-state and output decode for the command FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    step_d     = step_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    op_req_d   = op_req_q;
    op_we_d    = op_we_q;
    op_addr_d  = op_addr_q;
    op_wdata_d = op_wdata_q;

    cur_op     = seq_op(cmd_q, step_q, addr_q, data_q);
    n_steps    = seq_len(cmd_q);
    polled     = (cmd_q == CMD_PROGRAM) || (cmd_q == CMD_SECTOR) ||
                 (cmd_q == CMD_CHIP);
    // Program polls until DQ7 shows the true data bit; erase until DQ7=1.
    expect_dq7 = (cmd_q == CMD_PROGRAM) ? data_q[7] : 1'b1;
    tmo_inc    = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
`ifdef FLASH_VERIFY_EN
    pass_state = (cmd_q == CMD_PROGRAM) ? S_VERIFY : S_FIN;
`else
    pass_state = S_FIN;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_d   = bus.cmd_code;
          addr_d  = bus.cmd_addr;
          data_d  = bus.cmd_data;
          err_d   = ERR_OK;
          step_d  = 3'd0;
          tmo_d   = '0;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (n_steps == 3'd0) begin
          err_d   = ERR_VERIFY;
          state_d = S_FIN;
        end else begin
          op_req_d   = 1'b1;
          op_we_d    = cur_op.we;
          op_addr_d  = cur_op.addr;
          op_wdata_d = cur_op.data;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.op_ack) begin
          op_req_d = 1'b0;
          step_d   = step_q + 3'd1;
          if (cmd_q == CMD_READ) rdata_d = bus.op_rdata;
          if ((step_q + 3'd1) < n_steps) state_d = S_ISSUE;
          else if (polled)               state_d = S_POLL;
          else                           state_d = S_FIN;
        end
      end

      // Status read; op_req is always low on entry, which gives the idle gap.
      S_POLL: begin
        if (!op_req_q) begin
          op_req_d   = 1'b1;
          op_we_d    = 1'b0;
          op_addr_d  = addr_q;
          op_wdata_d = 8'h00;
        end else if (bus.op_ack) begin
          op_req_d = 1'b0;
          rdata_d  = bus.op_rdata;
          state_d  = S_CHK;
        end
      end

      S_CHK: begin
        if (rdata_q[7] == expect_dq7) begin
          state_d = pass_state;
        end else if (rdata_q[5]) begin
          state_d = S_DQ5RD;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_MAX) begin
            err_d   = ERR_TIMEOUT;
            state_d = S_RSTWR;
          end else begin
            state_d = S_POLL;
          end
        end
      end

      // DQ5 may rise just before DQ7 flips, so one more read decides.
      S_DQ5RD: begin
        if (!op_req_q) begin
          op_req_d   = 1'b1;
          op_we_d    = 1'b0;
          op_addr_d  = addr_q;
          op_wdata_d = 8'h00;
        end else if (bus.op_ack) begin
          op_req_d = 1'b0;
          rdata_d  = bus.op_rdata;
          if (bus.op_rdata[7] == expect_dq7) begin
            state_d = pass_state;
          end else begin
            err_d   = ERR_DQ5;
            state_d = S_RSTWR;
          end
        end
      end

      // Return the flash to read-array mode after a failed operation.
      S_RSTWR: begin
        if (!op_req_q) begin
          op_req_d   = 1'b1;
          op_we_d    = 1'b1;
          op_addr_d  = addr_q;
          op_wdata_d = 8'hF0;
        end else if (bus.op_ack) begin
          op_req_d = 1'b0;
          state_d  = S_FIN;
        end
      end

`ifdef FLASH_VERIFY_EN
      S_VERIFY: begin
        if (!op_req_q) begin
          op_req_d   = 1'b1;
          op_we_d    = 1'b0;
          op_addr_d  = addr_q;
          op_wdata_d = 8'h00;
        end else if (bus.op_ack) begin
          op_req_d = 1'b0;
          rdata_d  = bus.op_rdata;
          if (bus.op_rdata != data_q) err_d = ERR_VERIFY;
          state_d  = S_FIN;
        end
      end
`endif

      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.op_req    = op_req_q;
  assign bus.op_we     = op_we_q;
  assign bus.op_addr   = op_addr_q;
  assign bus.op_wdata  = op_wdata_q;

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Self-checking bench for flash_cmd_seq: a behavioural flash/rom-controller
// responder plus a command-level reference model of the JEDEC sequences.
// Honours FLASH_VERIFY_EN the same way as the design.
module tb_flash_cmd_seq;

  localparam int ADDR_W  = 19;
  localparam int TMO_W   = 4;
  localparam int TMO_MAX = (1 << TMO_W) - 1;

  logic clk;
  logic rst;

  flash_cmd_seq_if #(.ADDR_W(ADDR_W)) bus ();

  flash_cmd_seq #(.ADDR_W(ADDR_W), .TMO_W(TMO_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Responder configuration and records
  int          ack_delay   = 1;
  bit          spurious_en = 1'b0;
  logic [7:0]  rd_default  = 8'h00;
  logic [7:0]  rd_q[$];
  logic [27:0] ops_seen[$];
  int          proto_errs  = 0;

  // Reference model state
  logic [7:0]  plan[$];
  int          m_idx;
  logic [27:0] exp_ops[$];
  logic [1:0]  exp_err;
  logic [7:0]  m_rdata = 8'h00;

  function automatic logic [27:0] op_enc(input logic we, input logic [18:0] a,
                                         input logic [7:0] d);
    return {we, a, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Flash + rom controller: acks each op after ack_delay cycles of op_req,
  // checks the request stays stable and drops right after the ack.
  initial begin : responder
    bit          busy;
    int          cnt;
    logic [27:0] cur;
    logic [27:0] now_op;
    busy = 1'b0;
    cnt  = 0;
    cur  = '0;
    bus.op_ack   = 1'b0;
    bus.op_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bus.op_ack = 1'b0;
        busy = 1'b0;
        continue;
      end
      if (bus.op_ack) begin
        bus.op_ack = 1'b0;
        if (busy) begin
          busy = 1'b0;
          if (bus.op_req) proto_errs++;
          continue;
        end
      end
      now_op = op_enc(bus.op_we, bus.op_addr, bus.op_we ? bus.op_wdata : 8'h00);
      if (bus.op_req) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = 1;
          cur  = now_op;
        end else begin
          cnt++;
          if (now_op !== cur) proto_errs++;
        end
        if (cnt >= ack_delay) begin
          bus.op_ack = 1'b1;
          ops_seen.push_back(cur);
          if (cur[27]) bus.op_rdata = 8'($urandom);
          else if (rd_q.size() != 0) bus.op_rdata = rd_q.pop_front();
          else bus.op_rdata = rd_default;
        end
      end else begin
        if (busy) proto_errs++;
        else if (spurious_en && ($urandom_range(0, 3) == 0)) begin
          bus.op_ack   = 1'b1;
          bus.op_rdata = 8'($urandom);
        end
      end
    end
  end

  function automatic logic [7:0] model_read();
    logic [7:0] v;
    if (m_idx < plan.size()) v = plan[m_idx];
    else v = rd_default;
    m_idx++;
    return v;
  endfunction

  // Command-level reference: expected op list, err and rdata.
  task automatic model_cmd(input logic [2:0] code, input logic [18:0] a,
                           input logic [7:0] d);
    logic [7:0] v;
    logic       want;
    int         polls;
    bit         pass;
    exp_ops.delete();
    exp_err = 2'd0;
    m_idx   = 0;
    want    = 1'b1;
    if (code == 3'd0) begin
      v = model_read();
      exp_ops.push_back(op_enc(1'b0, a, 8'h00));
      m_rdata = v;
    end else if (code == 3'd4) begin
      exp_ops.push_back(op_enc(1'b1, a, 8'hF0));
    end else if (code <= 3'd3) begin
      exp_ops.push_back(op_enc(1'b1, 19'h555, 8'hAA));
      exp_ops.push_back(op_enc(1'b1, 19'h2AA, 8'h55));
      if (code == 3'd1) begin
        exp_ops.push_back(op_enc(1'b1, 19'h555, 8'hA0));
        exp_ops.push_back(op_enc(1'b1, a, d));
        want = d[7];
      end else begin
        exp_ops.push_back(op_enc(1'b1, 19'h555, 8'h80));
        exp_ops.push_back(op_enc(1'b1, 19'h555, 8'hAA));
        exp_ops.push_back(op_enc(1'b1, 19'h2AA, 8'h55));
        if (code == 3'd2) exp_ops.push_back(op_enc(1'b1, a, 8'h30));
        else exp_ops.push_back(op_enc(1'b1, 19'h555, 8'h10));
      end
      pass  = 1'b0;
      polls = 0;
      forever begin
        v = model_read();
        exp_ops.push_back(op_enc(1'b0, a, 8'h00));
        m_rdata = v;
        if (v[7] == want) begin
          pass = 1'b1;
          break;
        end
        if (v[5]) begin
          v = model_read();
          exp_ops.push_back(op_enc(1'b0, a, 8'h00));
          m_rdata = v;
          if (v[7] == want) pass = 1'b1;
          else exp_err = 2'd1;
          break;
        end
        polls++;
        if (polls == TMO_MAX) begin
          exp_err = 2'd2;
          break;
        end
      end
      if (!pass) exp_ops.push_back(op_enc(1'b1, a, 8'hF0));
`ifdef FLASH_VERIFY_EN
      if (pass && code == 3'd1) begin
        v = model_read();
        exp_ops.push_back(op_enc(1'b0, a, 8'h00));
        m_rdata = v;
        if (v != d) exp_err = 2'd3;
      end
`endif
    end else begin
      exp_err = 2'd3;
    end
  endtask

  task automatic wait_ready(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, ".ready"}, 32'(seen), 32'd1);
  endtask

  // Issue one command, let it run, compare against the model.
  task automatic run_cmd(input string tag, input logic [2:0] code,
                         input logic [18:0] a, input logic [7:0] d,
                         input bit poke);
    bit seen;
    int base;
    int perr0;
    model_cmd(code, a, d);
    rd_q  = plan;
    wait_ready(tag);
    base  = ops_seen.size();
    perr0 = proto_errs;
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = code;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    if (poke) begin
      check({tag, ".busy_ready"}, 32'(bus.cmd_ready), 32'd0);
      bus.cmd_valid = 1'b1;
      bus.cmd_code  = 3'd4;
      bus.cmd_addr  = 19'h7FFFF;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, ".done"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, ".err"}, 32'(bus.err), 32'(exp_err));
      check({tag, ".rdata"}, 32'(bus.rdata), 32'(m_rdata));
      check({tag, ".n_ops"}, 32'(ops_seen.size() - base), 32'(exp_ops.size()));
      for (int i = 0; i < exp_ops.size() && (base + i) < ops_seen.size(); i++)
        check($sformatf("%s.op%0d", tag, i), 32'(ops_seen[base + i]), 32'(exp_ops[i]));
      @(negedge clk);
      check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
      check({tag, ".ready_after"}, 32'(bus.cmd_ready), 32'd1);
    end
    check({tag, ".handshake"}, 32'(proto_errs - perr0), 32'd0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    logic [2:0]  code;
    logic [18:0] a;
    logic [7:0]  d;
    logic        want;
    int          r;
    bit          found;

    bus.cmd_valid = 1'b0;
    bus.cmd_code  = 3'd0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst.done",      32'(bus.done),      32'd0);
    check("rst.err",       32'(bus.err),       32'd0);
    check("rst.rdata",     32'(bus.rdata),     32'd0);
    check("rst.op_req",    32'(bus.op_req),    32'd0);
    check("rst.op_we",     32'(bus.op_we),     32'd0);
    check("rst.op_addr",   32'(bus.op_addr),   32'd0);
    check("rst.op_wdata",  32'(bus.op_wdata),  32'd0);
    rst = 1'b0;

    // PROGRAM with the 0x25 poll pattern (DQ5 set on the first status read)
    ack_delay = 1;
    plan = '{8'h25, 8'h25, 8'hA5};
    rd_default = 8'hA5;
    run_cmd("prog_dq5", 3'd1, 19'h12345, 8'hA5, 1'b0);

    // PROGRAM that toggles twice then completes
    plan = '{8'h05, 8'h05, 8'hA5};
    rd_default = 8'hA5;
    run_cmd("prog_ok", 3'd1, 19'h12345, 8'hA5, 1'b0);

    // SECTOR_ERASE with DQ5 failure
    plan = '{8'h20, 8'h20};
    rd_default = 8'h20;
    run_cmd("sector_dq5", 3'd2, 19'h70000, 8'h00, 1'b0);

    // CHIP_ERASE timing out, twice (timeout counter must restart)
    plan.delete();
    rd_default = 8'h00;
    run_cmd("chip_tmo1", 3'd3, 19'h00000, 8'h00, 1'b0);
    run_cmd("chip_tmo2", 3'd3, 19'h00000, 8'h00, 1'b0);

    // READ with slow ack and a command strobe while busy
    ack_delay = 3;
    plan = '{8'h5A};
    rd_default = 8'h00;
    run_cmd("read_slow", 3'd0, 19'h00100, 8'h00, 1'b1);

    // Illegal code
    ack_delay = 1;
    plan.delete();
    run_cmd("illegal6", 3'd6, 19'h00000, 8'h00, 1'b0);

    // Reset while PROGRAM's third write is on the bus
    ack_delay = 2;
    plan.delete();
    rd_q.delete();
    wait_ready("rst_mid");
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = 3'd1;
    bus.cmd_addr  = 19'h01234;
    bus.cmd_data  = 8'h3C;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.op_req && bus.op_we && bus.op_wdata == 8'hA0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_mid.reached_step2", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid.op_req",    32'(bus.op_req),    32'd0);
    check("rst_mid.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_mid.err",       32'(bus.err),       32'd0);
    check("rst_mid.rdata",     32'(bus.rdata),     32'd0);
    rst = 1'b0;
    m_rdata = 8'h00;

    // RESET command
    ack_delay = 1;
    run_cmd("reset_cmd", 3'd4, 19'h4ABCD, 8'h00, 1'b0);

    // Randomized commands, ack latencies and poll data
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 11);
      code = (r < 10) ? 3'(r % 5) : 3'(5 + (r % 3));
      a = 19'($urandom);
      d = 8'($urandom);
      ack_delay   = $urandom_range(1, 3);
      spurious_en = 1'($urandom_range(0, 1));
      want = (code == 3'd1) ? d[7] : 1'b1;
      plan.delete();
      for (int k = 0; k < $urandom_range(0, 5); k++) plan.push_back(8'($urandom));
      rd_default = {want, 7'($urandom)};
      run_cmd($sformatf("rand%0d", n), code, a, d, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
